// File: rtl/complex_power_sched_if.sv
// Bundle of the requester, power-unit and result signals of complex_power_sched.
// The scheduler takes the slave modport; sample sources / power unit / sink take master.
interface complex_power_sched_if #(
    parameter int N_CH = 4,
    parameter int CH_W = 2
);
    logic [N_CH-1:0]    i_req_vld;
    logic [N_CH*18-1:0] i_req_r;
    logic [N_CH*18-1:0] i_req_i;
    logic [N_CH-1:0]    o_req_rdy;
    logic [17:0]        o_pw_r;
    logic [17:0]        o_pw_i;
    logic [35:0]        i_pw_p;
    logic               o_vld;
    logic [CH_W-1:0]    o_ch;
    logic [35:0]        o_p;
    logic               o_busy;

    modport slave (
        input  i_req_vld, i_req_r, i_req_i, i_pw_p,
        output o_req_rdy, o_pw_r, o_pw_i, o_vld, o_ch, o_p, o_busy
    );

    modport master (
        output i_req_vld, i_req_r, i_req_i, i_pw_p,
        input  o_req_rdy, o_pw_r, o_pw_i, o_vld, o_ch, o_p, o_busy
    );
endinterface

// File: rtl/complex_power_sched.sv
// Round-robin scheduler sharing one complex |x|^2 unit among N_CH sample sources.
// Defining CPWR_SCHED_PEAK_EN adds per-channel peak-power tracking (i_peak_clr / o_peak).
module complex_power_sched #(
    parameter int N_CH   = 4,
    parameter int CH_W   = 2,
    parameter int PW_LAT = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
`ifdef CPWR_SCHED_PEAK_EN
    input  logic [N_CH-1:0]      i_peak_clr,
    output logic [N_CH*36-1:0]   o_peak,
`endif
    complex_power_sched_if.slave bus
);
    logic [CH_W-1:0]           ptr_q, ptr_d;
    logic [17:0]               pw_r_q, pw_r_d;
    logic [17:0]               pw_i_q, pw_i_d;
    logic [PW_LAT:0]           tag_vld_q, tag_vld_d;
    logic [PW_LAT:0][CH_W-1:0] tag_ch_q, tag_ch_d;
    logic                      vld_q, vld_d;
    logic [CH_W-1:0]           ch_q, ch_d;
    logic [35:0]               p_q, p_d;

    logic [CH_W-1:0]           cand;
    logic [CH_W-1:0]           gnt_ch;
    logic                      gnt_any;
    logic [N_CH-1:0]           grant;

    // Rotating-priority search from ptr; no grant is issued while reset is held.
    always_comb begin
        // NOTE: every combinational output is defaulted first so no latch is inferred.
        cand    = '0;
        gnt_ch  = '0;
        gnt_any = 1'b0;
        grant   = '0;
        for (int off = 0; off < N_CH; off++) begin
            cand = CH_W'((int'(ptr_q) + off) % N_CH);
            if (!gnt_any && bus.i_req_vld[cand]) begin
                gnt_any = 1'b1;
                gnt_ch  = cand;
            end
        end
        if (!i_rst_n) begin
            gnt_any = 1'b0;
        end
        if (gnt_any) begin
            grant[gnt_ch] = 1'b1;
        end
    end

    always_comb begin
        ptr_d     = ptr_q;
        pw_r_d    = pw_r_q;
        pw_i_d    = pw_i_q;
        tag_vld_d = {tag_vld_q[PW_LAT-1:0], gnt_any};
        tag_ch_d  = {tag_ch_q[PW_LAT-1:0], gnt_ch};
        if (gnt_any) begin
            ptr_d  = (gnt_ch == CH_W'(N_CH - 1)) ? '0 : gnt_ch + CH_W'(1);
            pw_r_d = bus.i_req_r[int'(gnt_ch) * 18 +: 18];
            pw_i_d = bus.i_req_i[int'(gnt_ch) * 18 +: 18];
        end
        // The last tag stage lines up with the power unit's result for that sample.
        vld_d = tag_vld_q[PW_LAT];
        ch_d  = tag_vld_q[PW_LAT] ? tag_ch_q[PW_LAT] : ch_q;
        p_d   = tag_vld_q[PW_LAT] ? bus.i_pw_p : p_q;
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!i_rst_n) begin
            ptr_q     <= '0;
            pw_r_q    <= '0;
            pw_i_q    <= '0;
            tag_vld_q <= '0;
            tag_ch_q  <= '0;
            vld_q     <= 1'b0;
            ch_q      <= '0;
            p_q       <= '0;
        end else begin
            ptr_q     <= ptr_d;
            pw_r_q    <= pw_r_d;
            pw_i_q    <= pw_i_d;
            tag_vld_q <= tag_vld_d;
            tag_ch_q  <= tag_ch_d;
            vld_q     <= vld_d;
            ch_q      <= ch_d;
            p_q       <= p_d;
        end
    end

    assign bus.o_req_rdy = grant;
    assign bus.o_pw_r    = pw_r_q;
    assign bus.o_pw_i    = pw_i_q;
    assign bus.o_vld     = vld_q;
    assign bus.o_ch      = ch_q;
    assign bus.o_p       = p_q;
    assign bus.o_busy    = |tag_vld_q;

`ifdef CPWR_SCHED_PEAK_EN
    logic [N_CH-1:0][35:0] peak_q, peak_d;

    // A clear coinciding with a result restarts the peak from that result.
    always_comb begin
        peak_d = peak_q;
        for (int c = 0; c < N_CH; c++) begin
            if (vld_q && (ch_q == CH_W'(c))) begin
                if (i_peak_clr[c] || (p_q > peak_q[c])) begin
                    peak_d[c] = p_q;
                end
            end else if (i_peak_clr[c]) begin
                peak_d[c] = '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign o_peak = peak_q;
`endif
endmodule

// File: tb/tb_complex_power_sched.sv
// Randomised scoreboard bench for complex_power_sched with a behavioural power unit.
// Build with CPWR_SCHED_PEAK_EN defined to also exercise the peak tracker.
module tb_complex_power_sched;
    localparam int N_CH   = 4;
    localparam int CH_W   = 2;
    localparam int PW_LAT = 3;

    typedef struct {
        int          ch;
        logic [35:0] p;
        longint      cyc;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    longint cyc = 0;
    int     n_vec = 0;
    int     n_err = 0;
    logic   mon_en = 1'b0;

    exp_t            sb_q[$];
    logic [N_CH-1:0] pend = '0;
    logic [17:0]     pend_r[N_CH];
    logic [17:0]     pend_i[N_CH];
    int              rr_start = 0;
    logic [17:0]     exp_pw_r = '0;
    logic [17:0]     exp_pw_i = '0;
    logic [35:0]     last_p = '0;
    int              last_ch = 0;
    logic            cur_vld = 1'b0;

    complex_power_sched_if #(.N_CH(N_CH), .CH_W(CH_W)) bus ();

`ifdef CPWR_SCHED_PEAK_EN
    logic [N_CH-1:0]    peak_clr = '0;
    logic [N_CH*36-1:0] peak;
    logic [35:0]        peak_exp[N_CH];
`endif

    complex_power_sched #(.N_CH(N_CH), .CH_W(CH_W), .PW_LAT(PW_LAT)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
`ifdef CPWR_SCHED_PEAK_EN
        .i_peak_clr (peak_clr),
        .o_peak     (peak),
`endif
        .bus        (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [35:0] pw_of(input logic [17:0] r, input logic [17:0] i);
        longint rv;
        longint iv;
        rv = longint'($signed(r));
        iv = longint'($signed(i));
        return 36'(rv * rv + iv * iv);
    endfunction

    // Behavioural power unit: PW_LAT register stages from o_pw_* to i_pw_p.
    logic [35:0] pu_q[PW_LAT];
    always @(posedge clk) begin
        pu_q[0] <= pw_of(bus.o_pw_r, bus.o_pw_i);
        for (int s = 1; s < PW_LAT; s++) pu_q[s] <= pu_q[s-1];
    end
    assign bus.i_pw_p = pu_q[PW_LAT-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [17:0] rnd18();
        case ($urandom_range(7))
            0:       return 18'h20000;
            1:       return 18'h1FFFF;
            2:       return 18'h00000;
            default: return 18'($urandom);
        endcase
    endfunction

    task automatic offer(input int c, input logic [17:0] r, input logic [17:0] i);
        pend[c]   = 1'b1;
        pend_r[c] = r;
        pend_i[c] = i;
    endtask

    // One cycle: drive at negedge, predict the grant from the round-robin rule, log the result.
    task automatic step(input logic rst_v, input logic [N_CH-1:0] clr_v);
        int              g;
        logic [N_CH-1:0] exp_rdy;
        @(negedge clk);
        rst_n         = rst_v;
        bus.i_req_vld = pend;
        for (int c = 0; c < N_CH; c++) begin
            bus.i_req_r[c*18 +: 18] = pend_r[c];
            bus.i_req_i[c*18 +: 18] = pend_i[c];
        end
`ifdef CPWR_SCHED_PEAK_EN
        peak_clr = clr_v;
        for (int c = 0; c < N_CH; c++) begin
            if (!rst_v) peak_exp[c] = '0;
            else if (cur_vld && last_ch == c)
                peak_exp[c] = (clr_v[c] || last_p > peak_exp[c]) ? last_p : peak_exp[c];
            else if (clr_v[c]) peak_exp[c] = '0;
        end
`else
        if (clr_v != clr_v) $display("unused");
`endif
        #1;
        g = -1;
        if (rst_v) begin
            for (int off = 0; off < N_CH; off++) begin
                if (g < 0 && pend[(rr_start + off) % N_CH]) g = (rr_start + off) % N_CH;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("o_req_rdy", bus.o_req_rdy, exp_rdy);
        if (!rst_v) begin
            sb_q.delete();
            rr_start = 0;
            exp_pw_r = '0;
            exp_pw_i = '0;
            last_p   = '0;
            last_ch  = 0;
        end else if (g >= 0) begin
            sb_q.push_back('{ch: g, p: pw_of(pend_r[g], pend_i[g]), cyc: cyc + 5});
            exp_pw_r = pend_r[g];
            exp_pw_i = pend_i[g];
            pend[g]  = 1'b0;
            rr_start = (g + 1) % N_CH;
        end
    endtask

    // Monitor: pops the scoreboard whenever a result is due and checks every output.
    initial begin
        exp_t e;
        logic exp_vld;
        logic busy_exp;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                busy_exp = 1'b0;
                foreach (sb_q[j]) if (sb_q[j].cyc > cyc && sb_q[j].cyc <= cyc + 4) busy_exp = 1'b1;
                exp_vld = (sb_q.size() > 0) && (sb_q[0].cyc == cyc);
                check("o_busy", bus.o_busy, busy_exp);
                check("o_vld", bus.o_vld, exp_vld);
                check("o_pw_r", bus.o_pw_r, exp_pw_r);
                check("o_pw_i", bus.o_pw_i, exp_pw_i);
                if (exp_vld) begin
                    e       = sb_q.pop_front();
                    last_p  = e.p;
                    last_ch = e.ch;
                end
                cur_vld = exp_vld;
                check("o_ch", bus.o_ch, last_ch);
                check("o_p", bus.o_p, last_p);
`ifdef CPWR_SCHED_PEAK_EN
                for (int c = 0; c < N_CH; c++)
                    check($sformatf("o_peak[%0d]", c), peak[c*36 +: 36], peak_exp[c]);
`endif
            end
        end
    end

    initial begin
        logic [N_CH-1:0] cv;
        for (int c = 0; c < N_CH; c++) begin
            pend_r[c] = '0;
            pend_i[c] = '0;
`ifdef CPWR_SCHED_PEAK_EN
            peak_exp[c] = '0;
`endif
        end
        bus.i_req_vld = '0;
        bus.i_req_r   = '0;
        bus.i_req_i   = '0;

        // Reset with no requests, then idle: everything stays zero.
        step(1'b0, '0);
        mon_en = 1'b1;
        repeat (4) step(1'b0, '0);
        repeat (5) step(1'b1, '0);

        // Lone ch2 sample 3+4j -> single result 25 on ch2.
        offer(2, 18'd3, 18'd4);
        repeat (8) step(1'b1, '0);

        // All channels requesting continuously from ptr 0.
        step(1'b0, '0);
        for (int t = 0; t < 12; t++) begin
            for (int c = 0; c < N_CH; c++) if (!pend[c]) offer(c, rnd18(), rnd18());
            step(1'b1, '0);
        end
        pend = '0;
        repeat (6) step(1'b1, '0);

        // ch0 always requesting; ch3 arrives with ptr at 1 and must be served.
        step(1'b0, '0);
        offer(0, 18'd1, 18'd1);
        step(1'b1, '0);
        offer(3, 18'd7, 18'd2);
        for (int t = 0; t < 4; t++) begin
            if (!pend[0]) offer(0, rnd18(), rnd18());
            step(1'b1, '0);
        end
        pend = '0;
        repeat (6) step(1'b1, '0);

        // Extremes: most-negative both parts gives 2^35, then zero.
        offer(1, 18'h20000, 18'h20000);
        step(1'b1, '0);
        offer(1, 18'h0, 18'h0);
        repeat (7) step(1'b1, '0);

        // Three in flight then reset: nothing emerges, next grant is ch0.
        step(1'b0, '0);
        offer(0, 18'd5, 18'd5);
        offer(1, 18'd6, 18'd6);
        offer(2, 18'd7, 18'd7);
        repeat (3) step(1'b1, '0);
        step(1'b0, '0);
        repeat (6) step(1'b1, '0);
        for (int c = 0; c < N_CH; c++) offer(c, 18'(c + 1), 18'd0);
        step(1'b1, '0);
        pend = '0;
        repeat (6) step(1'b1, '0);

`ifdef CPWR_SCHED_PEAK_EN
        // ch1 results 25, 100, 9 -> peak 100; clear with a concurrent 9 -> 9; clear alone -> 0.
        step(1'b0, '0);
        offer(1, 18'd3, 18'd4);
        step(1'b1, '0);
        offer(1, 18'd6, 18'd8);
        step(1'b1, '0);
        offer(1, 18'd3, 18'd0);
        repeat (6) step(1'b1, '0);
        offer(1, 18'd0, 18'h3FFFD);
        step(1'b1, '0);
        repeat (4) step(1'b1, '0);
        step(1'b1, 4'b0010);
        step(1'b1, '0);
        step(1'b1, 4'b0010);
        repeat (2) step(1'b1, '0);
`endif

        // Random traffic with drops, occasional resets and (if present) random peak clears.
        for (int t = 0; t < 400; t++) begin
            for (int c = 0; c < N_CH; c++) begin
                if (!pend[c] && $urandom_range(2) == 0) offer(c, rnd18(), rnd18());
                else if (pend[c] && $urandom_range(19) == 0) pend[c] = 1'b0;
            end
            cv = ($urandom_range(7) == 0) ? N_CH'($urandom) : '0;
            step(($urandom_range(149) != 0), cv);
        end
        pend = '0;
        repeat (8) step(1'b1, '0);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
